clock_divider_prog: RTL

Runtime-programmable successor to the fixed-ratio clock divider used in the NCO datapath. It divides clk_in by a period loaded at run time, with an independent high time, so odd ratios and non-50% duty cycles are supported. It also produces a one-cycle tick strobe per output period for downstream clock-enable use. Configuration changes go through a valid/ready handshake and take effect only at a period boundary, so clk_out never glitches; a sync input restarts the phase.

---
 rtl/clock_div_pkg.sv | 20 ++
 rtl/clock_div_cfg_shadow.sv | 50 +++++
 rtl/clock_divider_prog.sv | 93 +++++++++
 3 files changed

// File: rtl/clock_div_pkg.sv
// Shared constants and the configuration clamp for the programmable clock divider.
package clock_div_pkg;

    localparam int CNT_WIDTH_DEFAULT = 16;
    localparam int MIN_PERIOD        = 2;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] high;
    } clamp_t;

    // Works on 32-bit values so any CNT_WIDTH up to 32 can share one helper.
    function automatic clamp_t clamp_cfg(input logic [31:0] period, input logic [31:0] high);
        clamp_t r;
        r.period = (period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period;
        r.high   = (high > r.period) ? r.period : high;
        return r;
    endfunction

endpackage

// File: rtl/clock_div_cfg_shadow.sv
// Configuration shadow register: clamps an accepted offer and holds it until
// the divider reaches a point where it may be applied.
module clock_div_cfg_shadow
    import clock_div_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] i_cfg_period,
    input  logic [CNT_WIDTH-1:0] i_cfg_high,
    input  logic                 i_cfg_valid,
    input  logic                 i_consume,
    output logic                 o_cfg_ready,
    output logic                 o_apply,
    output logic [CNT_WIDTH-1:0] o_shadow_period,
    output logic [CNT_WIDTH-1:0] o_shadow_high
);

    logic                 r_pending;
    logic [CNT_WIDTH-1:0] r_shadow_period;
    logic [CNT_WIDTH-1:0] r_shadow_high;
    clamp_t               w_clamped;
    logic                 w_accept;

    assign w_clamped = clamp_cfg(32'(i_cfg_period), 32'(i_cfg_high));
    assign w_accept  = i_cfg_valid && !r_pending;

    // Accept and apply are mutually exclusive: accept needs !pending, apply needs pending.
    assign o_apply   = r_pending && i_consume;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= 1'b0;
            r_shadow_period <= '0;
            r_shadow_high   <= '0;
        end else if (w_accept) begin
            r_pending       <= 1'b1;
            r_shadow_period <= CNT_WIDTH'(w_clamped.period);
            r_shadow_high   <= CNT_WIDTH'(w_clamped.high);
        end else if (o_apply) begin
            r_pending       <= 1'b0;
        end
    end

    assign o_cfg_ready     = !r_pending;
    assign o_shadow_period = r_shadow_period;
    assign o_shadow_high   = r_shadow_high;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with independent high time, tick strobe,
// phase sync and glitch-free configuration switching at period boundaries.
module clock_divider_prog
    import clock_div_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT,
    parameter int DIV_RESET  = 4,
    parameter int HIGH_RESET = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 clk_out,
    output logic                 tick,
    output logic [CNT_WIDTH-1:0] act_period,
    output logic [CNT_WIDTH-1:0] act_high
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clk_out;
    logic                 r_tick;
    logic                 r_first;
    logic [CNT_WIDTH-1:0] r_act_period;
    logic [CNT_WIDTH-1:0] r_act_high;

    logic                 w_wrap;
    logic                 w_consume;
    logic                 w_apply;
    logic [CNT_WIDTH-1:0] w_shadow_period;
    logic [CNT_WIDTH-1:0] w_shadow_high;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_act_period_next;
    logic [CNT_WIDTH-1:0] w_act_high_next;

    assign w_wrap     = r_first || sync || (r_cnt == (r_act_period - CNT_WIDTH'(1)));
    // While idle the counter is parked at zero, so any pending config is safe to take.
    assign w_consume  = !en || w_wrap;
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + CNT_WIDTH'(1));

    clock_div_cfg_shadow #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cfg_shadow (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .i_cfg_period    (cfg_period),
        .i_cfg_high      (cfg_high),
        .i_cfg_valid     (cfg_valid),
        .i_consume       (w_consume),
        .o_cfg_ready     (cfg_ready),
        .o_apply         (w_apply),
        .o_shadow_period (w_shadow_period),
        .o_shadow_high   (w_shadow_high)
    );

    assign w_act_period_next = w_apply ? w_shadow_period : r_act_period;
    assign w_act_high_next   = w_apply ? w_shadow_high   : r_act_high;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_first      <= 1'b1;
            r_act_period <= CNT_WIDTH'(DIV_RESET);
            r_act_high   <= CNT_WIDTH'(HIGH_RESET);
        end else begin
            r_act_period <= w_act_period_next;
            r_act_high   <= w_act_high_next;
            if (en) begin
                r_cnt     <= w_cnt_next;
                r_clk_out <= (w_cnt_next < w_act_high_next);
                r_tick    <= w_wrap;
                r_first   <= 1'b0;
            end else begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                r_first   <= 1'b1;
            end
        end
    end

    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign act_period = r_act_period;
    assign act_high   = r_act_high;

endmodule
